// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// presents the returned word to a stallable fetch latch, and handles
// redirects (including discarding a response that is already in flight).
//
// Handshake: imem_req is a request strobe that is accepted in the same cycle
// that imem_gnt is high. The response arrives on a later cycle and is marked
// by imem_rvalid. On the output side, instr_valid qualifies instr_out/pc_out.
// An instruction is consumed on any cycle with instr_valid=1 and stall=0, and
// it holds unchanged while stall=1.
module fetch_unit #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             instr_valid,
  output logic             misaligned,
  output logic             state_dbg
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] fetch_pc;
  logic             kill;
  logic             slot_free;
  logic             grant;
  logic             load_resp;

  // The output slot can take a new instruction unless one is being held.
  assign slot_free = !(instr_valid && stall);

  // Request only from REQ, never during reset or a redirect cycle.
  assign imem_req  = (state_q == S_REQ) && !rst && !redirect && slot_free;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // A response is kept only when nothing asked for it to be discarded.
  assign load_resp = (state_q == S_WAIT) && imem_rvalid && !kill && !redirect;

  assign state_dbg = (state_q == S_WAIT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect keeps WAIT until the killed response returns.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      if ((state_q == S_WAIT) && imem_rvalid) begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ:   if (grant)       state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // PC, kill tracking and the output latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      kill        <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= NOP;
      pc_out      <= '0;
      misaligned  <= 1'b0;
    end else if (redirect) begin
      pc          <= {redirect_pc[WIDTH-1:2], 2'b00};
      instr_valid <= 1'b0;
      instr_out   <= NOP;
      if (redirect_pc[1:0] != 2'b00) begin
        misaligned <= 1'b1;
      end
      // An outstanding request must have its response thrown away; if the
      // response is arriving right now it is simply not loaded.
      if (state_q == S_WAIT) begin
        kill <= !imem_rvalid;
      end
    end else begin
      if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end
      if (grant) begin
        fetch_pc <= pc;
        pc       <= pc + WIDTH'(4);
      end
      if ((state_q == S_WAIT) && imem_rvalid && kill) begin
        kill <= 1'b0;
      end
      if (load_resp) begin
        instr_out   <= imem_rdata;
        pc_out      <= fetch_pc;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. The bench plays the instruction memory
// by hand, cycle by cycle, and checks outputs against hand-computed values.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        misaligned;
  logic        state_dbg;

  int checks;
  int errors;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Driver: grant cycle, then a 1-cycle response with data. Reports the
  // request strobe/address seen in the grant cycle and the strobe seen in
  // the response cycle.
  task automatic do_fetch(input logic [31:0] data, output logic req_g,
                          output logic [31:0] addr_g, output logic req_w);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    req_g  = imem_req;
    addr_g = imem_addr;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    #1;
    req_w = imem_req;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP || pc_out !== 32'h0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h pc_out=%h mis=%b expected 0/00000013/0/0",
               instr_valid, instr_out, pc_out, misaligned);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    logic rg; logic [31:0] ag; logic rw;
    logic [31:0] exp_addr [3];
    logic [31:0] exp_data [3];
    exp_addr = '{32'h0, 32'h4, 32'h8};
    exp_data = '{32'h0500_2030, 32'h1111_0001, 32'h2222_0002};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_fetch(exp_data[i], rg, ag, rw);
      checks++;
      if (rg !== 1'b1 || ag !== exp_addr[i]) begin
        errors++; $display("FAIL basic_req[%0d]: req=%b addr=%h expected 1/%h", i, rg, ag, exp_addr[i]);
      end
      checks++;
      if (rw !== 1'b0) begin
        errors++; $display("FAIL basic_wait_req[%0d]: got %b expected 0", i, rw);
      end
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== exp_data[i] || pc_out !== exp_addr[i]) begin
        errors++;
        $display("FAIL basic_out[%0d]: valid=%b instr=%h pc=%h expected 1/%h/%h",
                 i, instr_valid, instr_out, pc_out, exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic rg; logic [31:0] ag; logic rw;
    // Holding the word fetched from 0x8; pc is now 0xC.
    stall    = 1'b1;
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req);
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h2222_0002 || pc_out !== 32'h8) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h expected 1/22220002/00000008",
                 i, instr_valid, instr_out, pc_out);
      end
    end
    stall    = 1'b0;
    imem_gnt = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL stall_resume: req=%b addr=%h expected 1/0000000c", imem_req, imem_addr);
    end
    do_fetch(32'h3333_0003, rg, ag, rw);
    checks++;
    if (ag !== 32'hC || instr_out !== 32'h3333_0003 || pc_out !== 32'hC) begin
      errors++; $display("FAIL stall_next: addr=%h instr=%h pc=%h expected c/33330003/c", ag, instr_out, pc_out);
    end
  endtask

  task automatic test_redirect_outstanding();
    logic rg; logic [31:0] ag; logic rw;
    apply_reset();
    do_fetch(32'hA000_0000, rg, ag, rw);
    do_fetch(32'hA000_0004, rg, ag, rw);
    // Grant the request to 0x8, then redirect while it is outstanding.
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_req_supp: got %b expected 0", imem_req);
    end
    step();
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0008;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP) begin
      errors++; $display("FAIL redir_drop: valid=%b instr=%h expected 0/00000013", instr_valid, instr_out);
    end
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_next_addr: req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
    end
    do_fetch(32'hB000_0100, rg, ag, rw);
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 32'hB000_0100 || pc_out !== 32'h100) begin
      errors++; $display("FAIL redir_first: valid=%b instr=%h pc=%h expected 1/b0000100/100", instr_valid, instr_out, pc_out);
    end
    // Redirect in the very cycle the response arrives.
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0104;
    step();
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_same_cycle: valid=%b req=%b addr=%h expected 0/1/00000200", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    logic rg; logic [31:0] ag; logic rw;
    apply_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    imem_gnt    = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL mis_req_supp: got %b expected 0", imem_req);
    end
    step();
    redirect = 1'b0;
    imem_gnt = 1'b0;
    #1;
    checks++;
    if (misaligned !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL mis_set: mis=%b req=%b addr=%h expected 1/1/00000100", misaligned, imem_req, imem_addr);
    end
    do_fetch(32'hC000_0100, rg, ag, rw);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    checks++;
    if (misaligned !== 1'b1) begin
      errors++; $display("FAIL mis_sticky: got %b expected 1", misaligned);
    end
    apply_reset();
    checks++;
    if (misaligned !== 1'b0) begin
      errors++; $display("FAIL mis_clear: got %b expected 0", misaligned);
    end
  endtask

  task automatic test_wrap();
    logic rg; logic [31:0] ag; logic rw;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    do_fetch(32'hE000_FFFC, rg, ag, rw);
    checks++;
    if (ag !== 32'hFFFF_FFFC || pc_out !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req: addr=%h pc_out=%h expected fffffffc", ag, pc_out);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic rg; logic [31:0] ag; logic rw;
    do_fetch(32'h1234_0000, rg, ag, rw);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0004;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rstwait_req: got %b expected 0", imem_req);
    end
    step();
    imem_rvalid = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP) begin
      errors++; $display("FAIL rstwait_out: valid=%b instr=%h expected 0/00000013", instr_valid, instr_out);
    end
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rstwait_next: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    // A stray response while idle in REQ must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0008;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP) begin
      errors++; $display("FAIL rstwait_stray: valid=%b instr=%h expected 0/00000013", instr_valid, instr_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_outstanding();
    test_misaligned();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data and address width.
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL set the PC loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 stall  input  1  SHALL indicate the downstream fetch latch cannot accept the presented instruction.
REQ-006 redirect  input  1  SHALL request a control-flow change (branch/jump taken).
REQ-007 redirect_pc  input  WIDTH  SHALL be the new fetch address, sampled when redirect=1.
REQ-008 imem_req  output  1  SHALL be the instruction memory request strobe.
REQ-009 imem_addr  output  WIDTH  SHALL be the request address, equal to pc.
REQ-010 imem_gnt  input  1  SHALL signal request acceptance in the same cycle as imem_req.
REQ-011 imem_rvalid  input  1  SHALL mark imem_rdata as valid, at least one cycle after the grant.
REQ-012 imem_rdata  input  WIDTH  SHALL be the returned instruction word.
REQ-013 instr_out  output  WIDTH  SHALL be the instruction presented to the fetch latch.
REQ-014 pc_out  output  WIDTH  SHALL be the address of instr_out.
REQ-015 instr_valid  output  1  SHALL qualify instr_out and pc_out.
REQ-016 misaligned  output  1  SHALL be a sticky flag for a redirect to a non-word-aligned address.

Function
REQ-017 FSM states SHALL be REQ (issue request) and WAIT (one request outstanding); at most one request SHALL be outstanding.
REQ-018 imem_req SHALL be combinational: high only when state=REQ, rst=0, redirect=0, and the output slot is free or being consumed.
REQ-019 The output slot is free or being consumed when NOT (instr_valid=1 AND stall=1).
REQ-020 In REQ, when imem_req=1 and imem_gnt=1: fetch_pc <= pc; pc <= pc+4 (modulo 2^WIDTH, wraps to 0); state <= WAIT.
REQ-021 In REQ without a grant, pc SHALL hold and imem_req SHALL stay asserted while its conditions hold.
REQ-022 In WAIT, imem_req SHALL be 0; on imem_rvalid=1 with kill=0: instr_out <= imem_rdata; pc_out <= fetch_pc; instr_valid <= 1; state <= REQ.
REQ-023 An instruction SHALL be consumed on any cycle where instr_valid=1 and stall=0; instr_valid SHALL then clear next cycle unless a new response loads that same cycle.
REQ-024 While instr_valid=1 and stall=1, instr_out, pc_out and instr_valid SHALL hold unchanged.
REQ-025 Redirect SHALL have priority over all other events:
- pc <= {redirect_pc[WIDTH-1:2],2'b00}
- instr_valid <= 0
- instr_out <= 32'h00000013 (NOP)
REQ-026 Redirect in WAIT with imem_rvalid=0 SHALL set kill=1; the next response SHALL then be discarded, kill cleared, and state <= REQ.
REQ-027 Redirect in WAIT with imem_rvalid=1 in the same cycle SHALL discard that response and set state <= REQ, with kill=0.
REQ-028 Redirect in REQ SHALL suppress the request that cycle; the first request from the new pc SHALL issue the next cycle.
REQ-029 redirect=1 with redirect_pc[1:0]!=0 SHALL set misaligned=1 until reset.
REQ-030 Fetch-to-output latency SHALL be: grant cycle, then response cycle, with instr_valid high the cycle after imem_rvalid.

Reset
REQ-031 While rst=1 at a clock edge:
- pc <= RESET_PC, fetch_pc <= RESET_PC
- state <= REQ, kill <= 0
- instr_valid <= 0, instr_out <= 32'h00000013, pc_out <= 0
- misaligned <= 0
REQ-032 Reset SHALL override redirect and abandon any outstanding request; a late imem_rvalid after reset SHALL be ignored while kill is clear and state=REQ.
REQ-033 The first request SHALL issue the cycle after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-034 Reset, then memory grants immediately with 1-cycle response -> imem_addr sequence 0,4,8; instr_out 0x05002030 with pc_out 0 and instr_valid=1.
REQ-035 stall=1 while instr_valid=1 for 3 cycles -> instr_out and pc_out hold, imem_req=0; after stall drops, the next request issues from the held pc.
REQ-036 redirect to 0x100 while a request to 0x8 is outstanding -> the 0x8 response is dropped (instr_valid stays 0); the next imem_addr is 0x100.
REQ-037 redirect to 0x102 -> imem_addr=0x100 next cycle; misaligned=1 and remains 1 until rst.
REQ-038 pc=0xFFFFFFFC granted -> next imem_addr=0x00000000.
REQ-039 rst asserted mid-WAIT, with imem_rvalid arriving during reset -> instr_valid=0, instr_out=0x00000013, next imem_addr=RESET_PC.
